// File: rtl/morse_pkg.sv
// Shared Morse timing ratios, ASCII constants and symbol typedefs.
// Used by the decoder now and by sender/receiver going forward.
package morse_pkg;

    localparam int DOT      = 1;
    localparam int DASH     = 3;
    localparam int CHAR_GAP = 3;
    localparam int WORD_GAP = 7;

    // Decision thresholds in units: dot/dash split and char end, word end.
    localparam int CHAR_THRESH = 2;
    localparam int WORD_THRESH = 5;
    localparam int SAT_UNITS   = 8;

    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef logic [7:0] pattern_t;
    typedef logic [3:0] nsym_t;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP
    } state_t;

endpackage

// File: rtl/morse_decoder_if.sv
// Character output handshake of the Morse decoder.
// Decoder is master; the character consumer is slave.
interface morse_decoder_if;
    logic [7:0] o_char;
    logic       o_valid;
    logic       i_ready;

    modport master (
        output o_char,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_char,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/morse_lut.sv
// Combinational Morse (pattern, length) to ASCII lookup.
// Pattern holds the first symbol in bit nsym-1; dot=0, dash=1.
module morse_lut
    import morse_pkg::*;
#(
    parameter int MAX_SYMBOLS = 6
) (
    input  logic [MAX_SYMBOLS-1:0] pattern,
    input  nsym_t                  nsym,
    output logic [7:0]             ascii
);

    pattern_t p;

    always_comb begin
        p = '0;
        p[MAX_SYMBOLS-1:0] = pattern;
        ascii = ASCII_QMARK;
        case ({nsym, p})
            {4'd2, 8'd1}:  ascii = 8'h41;
            {4'd4, 8'd8}:  ascii = 8'h42;
            {4'd4, 8'd10}: ascii = 8'h43;
            {4'd3, 8'd4}:  ascii = 8'h44;
            {4'd1, 8'd0}:  ascii = 8'h45;
            {4'd4, 8'd2}:  ascii = 8'h46;
            {4'd3, 8'd6}:  ascii = 8'h47;
            {4'd4, 8'd0}:  ascii = 8'h48;
            {4'd2, 8'd0}:  ascii = 8'h49;
            {4'd4, 8'd7}:  ascii = 8'h4A;
            {4'd3, 8'd5}:  ascii = 8'h4B;
            {4'd4, 8'd4}:  ascii = 8'h4C;
            {4'd2, 8'd3}:  ascii = 8'h4D;
            {4'd2, 8'd2}:  ascii = 8'h4E;
            {4'd3, 8'd7}:  ascii = 8'h4F;
            {4'd4, 8'd6}:  ascii = 8'h50;
            {4'd4, 8'd13}: ascii = 8'h51;
            {4'd3, 8'd2}:  ascii = 8'h52;
            {4'd3, 8'd0}:  ascii = 8'h53;
            {4'd1, 8'd1}:  ascii = 8'h54;
            {4'd3, 8'd1}:  ascii = 8'h55;
            {4'd4, 8'd1}:  ascii = 8'h56;
            {4'd3, 8'd3}:  ascii = 8'h57;
            {4'd4, 8'd9}:  ascii = 8'h58;
            {4'd4, 8'd11}: ascii = 8'h59;
            {4'd4, 8'd12}: ascii = 8'h5A;
            {4'd5, 8'd31}: ascii = 8'h30;
            {4'd5, 8'd15}: ascii = 8'h31;
            {4'd5, 8'd7}:  ascii = 8'h32;
            {4'd5, 8'd3}:  ascii = 8'h33;
            {4'd5, 8'd1}:  ascii = 8'h34;
            {4'd5, 8'd0}:  ascii = 8'h35;
            {4'd5, 8'd16}: ascii = 8'h36;
            {4'd5, 8'd24}: ascii = 8'h37;
            {4'd5, 8'd28}: ascii = 8'h38;
            {4'd5, 8'd30}: ascii = 8'h39;
            default:       ascii = ASCII_QMARK;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse line decoder: times marks/spaces in clock cycles, classifies
// dots/dashes and emits ASCII characters over a valid/ready port.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int MAX_SYMBOLS = 6
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_data_morse,
    morse_decoder_if.master bus,
    output logic            o_overflow,
    output logic            o_busy
);

    localparam int CNT_MAX = SAT_UNITS * UNIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] DOT_MIN  = CNT_W'(UNIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(CHAR_THRESH * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CHAR_CNT = CNT_W'(CHAR_THRESH * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_THRESH * UNIT_CYCLES);

    logic                   sync1;
    logic                   line;
    logic                   prev;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    state_t                 state;
    logic [MAX_SYMBOLS-1:0] pattern;
    nsym_t                  nsym;
    logic                   overlong;
    logic                   word_pending;
    logic [7:0]             lut_char;
    logic                   emit;
    logic [7:0]             emit_char;

    morse_lut #(
        .MAX_SYMBOLS(MAX_SYMBOLS)
    ) u_lut (
        .pattern(pattern),
        .nsym   (nsym),
        .ascii  (lut_char)
    );

    // Run length of the current synchronised level, restarting at 1.
    always_comb begin
        cnt_next = cnt;
        if (line != prev) cnt_next = CNT_W'(1);
        else if (cnt != CNT_SAT) cnt_next = cnt + 1'b1;
    end

    always_comb begin
        emit      = 1'b0;
        emit_char = overlong ? ASCII_QMARK : lut_char;
        if (state == GAP && !line) begin
            if (cnt_next == CHAR_CNT && nsym != '0) begin
                emit = 1'b1;
            end else if (cnt_next == WORD_CNT && word_pending) begin
                emit      = 1'b1;
                emit_char = ASCII_SPACE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 1'b0;
            line  <= 1'b0;
            prev  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= i_data_morse;
            line  <= sync1;
            prev  <= line;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            pattern      <= '0;
            nsym         <= '0;
            overlong     <= 1'b0;
            word_pending <= 1'b0;
            o_busy       <= 1'b0;
            o_overflow   <= 1'b0;
            bus.o_char   <= '0;
            bus.o_valid  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (line) begin
                        state  <= MARK;
                        o_busy <= 1'b1;
                    end
                end
                MARK: begin
                    if (!line) begin
                        if (cnt < DOT_MIN) begin
                            if (nsym != '0) begin
                                state <= GAP;
                            end else begin
                                state  <= IDLE;
                                o_busy <= 1'b0;
                            end
                        end else begin
                            if (nsym == nsym_t'(MAX_SYMBOLS)) begin
                                overlong <= 1'b1;
                            end else begin
                                pattern <= {pattern[MAX_SYMBOLS-2:0],
                                            cnt >= DASH_MIN};
                                nsym    <= nsym + 1'b1;
                            end
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (line) begin
                        state <= MARK;
                    end else if (emit) begin
                        if (nsym != '0) begin
                            pattern      <= '0;
                            nsym         <= '0;
                            overlong     <= 1'b0;
                            word_pending <= 1'b1;
                        end else begin
                            word_pending <= 1'b0;
                            state        <= IDLE;
                            o_busy       <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase

            // A full, unaccepted output register drops the new character.
            if (emit) begin
                if (!bus.o_valid || bus.i_ready) begin
                    bus.o_char  <= emit_char;
                    bus.o_valid <= 1'b1;
                end else begin
                    o_overflow <= 1'b1;
                end
            end else if (bus.i_ready) begin
                bus.o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Randomised scoreboard bench for morse_decoder with a string-table
// Morse reference model plus directed timing/backpressure/reset cases.
module tb_morse_decoder;

    localparam int U    = 4;
    localparam int MAXS = 6;

    logic clk;
    logic rst_n;
    logic raw;
    logic overflow;
    logic busy;

    int tests;
    int fails;

    logic [7:0] exp_q[$];

    string tab[36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....",
        "--...", "---..", "----."
    };

    morse_decoder_if bus();

    morse_decoder #(
        .UNIT_CYCLES(U),
        .MAX_SYMBOLS(MAXS)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_data_morse(raw),
        .bus         (bus),
        .o_overflow  (overflow),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_char(input string code);
        if (code.len() > MAXS) return 8'h3F;
        for (int i = 0; i < 36; i++) begin
            if (tab[i] == code) begin
                if (i < 26) return 8'(65 + i);
                return 8'(48 + i - 26);
            end
        end
        return 8'h3F;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        raw = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_code(input string code, input int dot,
                             input int dash, input int intra);
        for (int i = 0; i < code.len(); i++) begin
            if (i > 0) hold(1'b0, intra);
            hold(1'b1, (code[i] == 8'h2D) ? dash : dot);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_char", {24'h0, bus.o_char}, 32'h100);
                end else begin
                    check("char", {24'h0, bus.o_char},
                          {24'h0, exp_q.pop_front()});
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int nsym;
        int gap;
        string code;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        raw   = 1'b0;
        bus.i_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_valid", bus.o_valid, 0);
        check("rst_char", bus.o_char, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 'E' latency and one-cycle valid pulse
        exp_q.push_back(ref_char("."));
        exp_q.push_back(8'h20);
        hold(1'b1, U);
        raw = 1'b0;
        lat = 0;
        while (!bus.o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("e_latency", lat, 2 + 2 * U);
        @(negedge clk);
        check("e_pulse", bus.o_valid, 0);
        hold(1'b0, 30);
        check("e_idle_busy", busy, 0);
        drain("e_drain");

        // SOS then word gap
        exp_q.push_back(ref_char("..."));
        exp_q.push_back(ref_char("---"));
        exp_q.push_back(ref_char("..."));
        exp_q.push_back(8'h20);
        send_code("...", U, 3 * U, U);
        hold(1'b0, 3 * U);
        send_code("---", U, 3 * U, U);
        hold(1'b0, 3 * U);
        send_code("...", U, 3 * U, U);
        hold(1'b0, 7 * U);
        drain("sos_drain");
        check("sos_overflow", overflow, 0);

        // six and seven dots
        exp_q.push_back(ref_char("......"));
        exp_q.push_back(8'h20);
        send_code("......", U, 3 * U, U);
        hold(1'b0, 7 * U);
        exp_q.push_back(ref_char("......."));
        exp_q.push_back(8'h20);
        send_code(".......", U, 3 * U, U);
        hold(1'b0, 7 * U);
        drain("long_drain");

        // glitch inside the gap after 'T'
        exp_q.push_back(ref_char("-"));
        exp_q.push_back(8'h20);
        hold(1'b1, 3 * U);
        hold(1'b0, 3);
        hold(1'b1, 1);
        check("glitch_busy", busy, 1);
        hold(1'b0, 8 * U);
        drain("glitch_drain");

        // randomised character stream
        for (int c = 0; c < 40; c++) begin
            code = "";
            nsym = $urandom_range(1, 7);
            for (int k = 0; k < nsym; k++) begin
                if ($urandom_range(0, 1) == 1) code = {code, "-"};
                else code = {code, "."};
            end
            exp_q.push_back(ref_char(code));
            for (int k = 0; k < code.len(); k++) begin
                if (k > 0) hold(1'b0, $urandom_range(2, 2 * U - 1));
                if (code[k] == 8'h2D) hold(1'b1, $urandom_range(2 * U, 9 * U));
                else hold(1'b1, $urandom_range(U / 2, 2 * U - 1));
            end
            if ($urandom_range(0, 1) == 1 || c == 39) begin
                gap = $urandom_range(5 * U, 9 * U);
                exp_q.push_back(8'h20);
            end else begin
                gap = $urandom_range(2 * U, 5 * U - 1);
            end
            hold(1'b0, gap);
        end
        drain("rand_drain");
        check("rand_overflow", overflow, 0);

        // backpressure across "ET"
        @(negedge clk);
        bus.i_ready = 1'b0;
        exp_q.push_back(ref_char("."));
        send_code(".", U, 3 * U, U);
        hold(1'b0, 3 * U);
        send_code("-", U, 3 * U, U);
        hold(1'b0, 7 * U);
        check("bp_char", bus.o_char, 8'h45);
        check("bp_valid", bus.o_valid, 1);
        check("bp_overflow", overflow, 1);
        bus.i_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_fall", bus.o_valid, 0);
        check("bp_overflow_sticky", overflow, 1);
        drain("bp_drain");

        // reset in the middle of a dash
        hold(1'b1, 2 * U);
        check("dash_busy", busy, 1);
        rst_n = 1'b0;
        raw   = 1'b0;
        #1;
        check("mid_rst_valid", bus.o_valid, 0);
        check("mid_rst_char", bus.o_char, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 40);
        check("post_rst_quiet", bus.o_valid, 0);

        exp_q.push_back(ref_char("."));
        exp_q.push_back(8'h20);
        send_code(".", U, 3 * U, U);
        hold(1'b0, 8 * U);
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
- Receive-side decoder for the on-off keyed Morse line driven by `sender`, for example `o_data_morse`.
- Measures mark and space durations in units of UNIT_CYCLES clocks and classifies each mark as a dot or a dash.
- Emits each decoded character as 8-bit ASCII on a valid/ready interface. Unknown patterns decode to '?' and word gaps decode to ' '.
- Sits beside `receiver` as the character-level back end for future loopback and UART bridging.

Parameters:
- UNIT_CYCLES, 4, clock cycles per Morse time unit (dot length); must be >= 2.
- MAX_SYMBOLS, 6, maximum dots/dashes per character; a longer character decodes to '?'.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_data_morse  input  1  raw Morse line: high = mark (tone), low = space. Asynchronous to i_clk.
- o_char  output  8  decoded ASCII character, stable while o_valid is high.
- o_valid  output  1  o_char holds an undelivered character.
- i_ready  input  1  consumer accepts o_char on any cycle where o_valid and i_ready are both high.
- o_overflow  output  1  sticky flag: a character was dropped because the output register was full.
- o_busy  output  1  high while the FSM is in MARK or GAP.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - All outputs 0; FSM to IDLE.
  - Counter, pattern, symbol count, sync flops and word_pending cleared.
  - A reset mid-character discards that character without emitting it.
- Input synchronisation: 2-flop synchroniser on i_data_morse. All timing uses the synchronised level `line`, which lags the raw input by 2 cycles.
- Counter:
  - Counts consecutive cycles of the current line level.
  - Restarts at 1 on every level change.
  - Saturates at 8*UNIT_CYCLES.
- FSM states:
  - IDLE: line low, no character in progress. On line=1 go to MARK.
  - MARK, on line falling:
    - count < UNIT_CYCLES/2: glitch, discard with no symbol; return to GAP if nsym>0, else IDLE.
    - count < 2*UNIT_CYCLES: dot.
    - count >= 2*UNIT_CYCLES: dash.
    - A dot or dash is shifted in MSB-first (dot=0, dash=1), nsym increments, and the FSM goes to GAP.
    - If nsym was already MAX_SYMBOLS, set the overlong flag instead of shifting.
  - GAP:
    - On the cycle count reaches 2*UNIT_CYCLES with nsym>0: emit character, clear pattern/nsym/overlong, set word_pending.
    - On the cycle count reaches 5*UNIT_CYCLES with word_pending: emit 0x20, clear word_pending, go to IDLE.
    - line=1 before either threshold: go to MARK (intra-character gap).
- Emission:
  - Lookup of (pattern, nsym) gives A–Z (0x41–0x5A) and 0–9 (0x30–0x39).
  - Any other pattern, or an overlong character, gives 0x3F.
  - If o_valid=0, or o_valid=1 with i_ready=1 in the same cycle: o_char and o_valid=1 are registered on the next edge.
  - Otherwise the character is dropped, o_char is unchanged, and o_overflow is set. o_overflow clears only on reset.
- Latency: o_valid rises 2 + 2*UNIT_CYCLES cycles after the raw falling edge that ends a character's last mark.
- Handshake: o_valid falls on the edge after a cycle with i_ready=1 unless a new emission coincides. o_char never changes while o_valid=1 and i_ready=0.
- Marks at or beyond saturation: still a dash; no error.
- Line high at reset release: treated as a mark starting at the first cycle after reset.

Decomposition:
- Shared package `morse_pkg`, shared with `sender`/`receiver`:
  - Timing ratio constants: DOT=1, DASH=3, CHAR_GAP=3, WORD_GAP=7, and the decision thresholds 2 and 5.
  - ASCII constants for '?' and ' '.
  - Pattern/length typedef.
- One natural sub-module: `morse_lut`, combinational (pattern[MAX_SYMBOLS-1:0], nsym) -> ASCII[7:0], reusable by a future table-driven sender.

Test Plan:
- 'E': 4 high, 12 low, i_ready=1 -> o_char=0x45, o_valid pulses 1 cycle, 10 cycles after the falling edge.
- "SOS" (dot/dash = 4/12 high, 4 low intra, 12 low inter), then 28 low -> 0x53, 0x4F, 0x53, 0x20 in order; no overflow.
- Six dots -> 0x3F. Seven dots -> 0x3F. 1-cycle high glitch inside a gap -> ignored, 'T' (12 high) still gives 0x54.
- i_ready=0 throughout "ET" -> o_char holds 0x45 and o_valid stays 1; 'T' dropped and o_overflow=1. Raise i_ready -> o_valid falls, o_overflow stays 1.
- Assert i_rst_n=0 for 1 cycle mid-dash of 'T' -> all outputs 0 immediately, nothing emitted. A following 'E' decodes to 0x45.
